// File: rtl/color_filter_pkg.sv
// Shared types and constants for the red colour filter controller and its
// comparator.
package color_filter_pkg;

  localparam logic [11:0] RED_MIN_DEF    = 12'h700;
  localparam logic [11:0] GREEN_MAX_DEF  = 12'h4FF;
  localparam logic [11:0] BLUE_MAX_DEF   = 12'h4FF;
  localparam logic [10:0] COORD_MIN_INIT = 11'h7FF;

  typedef enum logic [1:0] {
    CFG_RED_MIN   = 2'd0,
    CFG_GREEN_MAX = 2'd1,
    CFG_BLUE_MAX  = 2'd2,
    CFG_COMMIT    = 2'd3
  } cfg_addr_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FRAME  = 2'd1,
    S_REPORT = 2'd2
  } state_e;

endpackage

// File: rtl/color_match.sv
// Combinational red-filter threshold compare; all compares are unsigned and
// strict so the pixel datapath and the controller agree bit for bit.
module color_match (
  input  logic [11:0] iRed,
  input  logic [11:0] iGreen,
  input  logic [11:0] iBlue,
  input  logic [11:0] iRedMin,
  input  logic [11:0] iGreenMax,
  input  logic [11:0] iBlueMax,
  output logic        oMatch
);

  assign oMatch = (iRed > iRedMin) && (iGreen < iGreenMax) && (iBlue < iBlueMax);

endmodule

// File: rtl/color_filter_ctrl.sv
// Red colour filter controller: shadow/active thresholds swapped only at frame
// boundaries, per-pixel match flag, and per-frame match count and bounding box.
module color_filter_ctrl
  import color_filter_pkg::*;
#(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int CNT_W = 20
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic [10:0]      iX_Cont,
  input  logic [10:0]      iY_Cont,
  input  logic [11:0]      iRed,
  input  logic [11:0]      iGreen,
  input  logic [11:0]      iBlue,
  input  logic             iDVAL,
  input  logic             iCfgValid,
  output logic             oCfgReady,
  input  logic [1:0]       iCfgAddr,
  input  logic [11:0]      iCfgData,
  output logic [11:0]      oRedMin,
  output logic [11:0]      oGreenMax,
  output logic [11:0]      oBlueMax,
  output logic             oMatch,
  output logic             oMatchDVAL,
  output logic             oFrameDone,
  output logic [CNT_W-1:0] oPixCount,
  output logic [10:0]      oXMin,
  output logic [10:0]      oXMax,
  output logic [10:0]      oYMin,
  output logic [10:0]      oYMax,
  output logic             oBoxValid
);

  localparam logic [10:0]      X_LAST  = 11'(IMG_W - 1);
  localparam logic [10:0]      Y_LAST  = 11'(IMG_H - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e state_q, state_d;
  logic pending_q, pending_d;
  logic [11:0] redMinAct_q, greenMaxAct_q, blueMaxAct_q;
  logic [11:0] redMinShd_q, greenMaxShd_q, blueMaxShd_q;
  logic [11:0] redThr, greenThr, blueThr;
  logic match_q, matchDval_q;
  logic [CNT_W-1:0] cntAcc_q, cntAcc_d;
  logic [10:0] xMinAcc_q, xMinAcc_d, xMaxAcc_q, xMaxAcc_d;
  logic [10:0] yMinAcc_q, yMinAcc_d, yMaxAcc_q, yMaxAcc_d;
  logic [CNT_W-1:0] pixCount_q;
  logic [10:0] xMin_q, xMax_q, yMin_q, yMax_q;
  logic boxValid_q;
  logic fs, fe, cfgAccept, loadActive, accumulate, statsLoad, hasMatch, pixMatch;

  assign fs = iDVAL && (iX_Cont == 11'd0) && (iY_Cont == 11'd0);
  assign fe = iDVAL && (iX_Cont == X_LAST) && (iY_Cont == Y_LAST);
  assign cfgAccept  = iCfgValid && !pending_q;
  // Outside a frame a pending commit lands at once; inside, only at the next FS.
  assign loadActive = pending_q && (fs || (state_q != S_FRAME));
  assign accumulate = iDVAL && (fs || (state_q == S_FRAME));
  assign statsLoad  = (state_q == S_FRAME) && fe && !fs;

  // The FS pixel is judged by the thresholds it swaps in.
  assign redThr   = (fs && pending_q) ? redMinShd_q   : redMinAct_q;
  assign greenThr = (fs && pending_q) ? greenMaxShd_q : greenMaxAct_q;
  assign blueThr  = (fs && pending_q) ? blueMaxShd_q  : blueMaxAct_q;

  color_match u_match (
    .iRed      (iRed),
    .iGreen    (iGreen),
    .iBlue     (iBlue),
    .iRedMin   (redThr),
    .iGreenMax (greenThr),
    .iBlueMax  (blueThr),
    .oMatch    (pixMatch)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (fs) state_d = S_FRAME;
      S_FRAME:  if (!fs && fe) state_d = S_REPORT;
      S_REPORT: state_d = fs ? S_FRAME : S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pending_d = pending_q;
    if (loadActive) pending_d = 1'b0;
    if (cfgAccept && (cfg_addr_e'(iCfgAddr) == CFG_COMMIT)) pending_d = 1'b1;
  end

  always_comb begin
    cntAcc_d  = fs ? '0 : cntAcc_q;
    xMinAcc_d = fs ? COORD_MIN_INIT : xMinAcc_q;
    xMaxAcc_d = fs ? '0 : xMaxAcc_q;
    yMinAcc_d = fs ? COORD_MIN_INIT : yMinAcc_q;
    yMaxAcc_d = fs ? '0 : yMaxAcc_q;
    if (accumulate && pixMatch) begin
      if (cntAcc_d != CNT_MAX) cntAcc_d = cntAcc_d + CNT_W'(1);
      if (iX_Cont < xMinAcc_d) xMinAcc_d = iX_Cont;
      if (iX_Cont > xMaxAcc_d) xMaxAcc_d = iX_Cont;
      if (iY_Cont < yMinAcc_d) yMinAcc_d = iY_Cont;
      if (iY_Cont > yMaxAcc_d) yMaxAcc_d = iY_Cont;
    end
    hasMatch = (cntAcc_d != '0);
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q       <= S_IDLE;
      pending_q     <= 1'b0;
      redMinAct_q   <= RED_MIN_DEF;
      greenMaxAct_q <= GREEN_MAX_DEF;
      blueMaxAct_q  <= BLUE_MAX_DEF;
      redMinShd_q   <= RED_MIN_DEF;
      greenMaxShd_q <= GREEN_MAX_DEF;
      blueMaxShd_q  <= BLUE_MAX_DEF;
      match_q       <= 1'b0;
      matchDval_q   <= 1'b0;
      cntAcc_q      <= '0;
      xMinAcc_q     <= COORD_MIN_INIT;
      xMaxAcc_q     <= '0;
      yMinAcc_q     <= COORD_MIN_INIT;
      yMaxAcc_q     <= '0;
      pixCount_q    <= '0;
      xMin_q        <= '0;
      xMax_q        <= '0;
      yMin_q        <= '0;
      yMax_q        <= '0;
      boxValid_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      match_q     <= iDVAL && pixMatch;
      matchDval_q <= iDVAL;
      cntAcc_q    <= cntAcc_d;
      xMinAcc_q   <= xMinAcc_d;
      xMaxAcc_q   <= xMaxAcc_d;
      yMinAcc_q   <= yMinAcc_d;
      yMaxAcc_q   <= yMaxAcc_d;
      if (loadActive) begin
        redMinAct_q   <= redMinShd_q;
        greenMaxAct_q <= greenMaxShd_q;
        blueMaxAct_q  <= blueMaxShd_q;
      end
      if (cfgAccept) begin
        unique case (cfg_addr_e'(iCfgAddr))
          CFG_RED_MIN:   redMinShd_q   <= iCfgData;
          CFG_GREEN_MAX: greenMaxShd_q <= iCfgData;
          CFG_BLUE_MAX:  blueMaxShd_q  <= iCfgData;
          default:       ;
        endcase
      end
      // Stats include the FE pixel and are visible during the REPORT cycle.
      if (statsLoad) begin
        pixCount_q <= cntAcc_d;
        boxValid_q <= hasMatch;
        xMin_q     <= hasMatch ? xMinAcc_d : '0;
        xMax_q     <= hasMatch ? xMaxAcc_d : '0;
        yMin_q     <= hasMatch ? yMinAcc_d : '0;
        yMax_q     <= hasMatch ? yMaxAcc_d : '0;
      end
    end
  end

  assign oCfgReady  = !pending_q;
  assign oRedMin    = redMinAct_q;
  assign oGreenMax  = greenMaxAct_q;
  assign oBlueMax   = blueMaxAct_q;
  assign oMatch     = match_q;
  assign oMatchDVAL = matchDval_q;
  assign oFrameDone = (state_q == S_REPORT);
  assign oPixCount  = pixCount_q;
  assign oXMin      = xMin_q;
  assign oXMax      = xMax_q;
  assign oYMin      = yMin_q;
  assign oYMax      = yMax_q;
  assign oBoxValid  = boxValid_q;

endmodule

// File: tb/tb_color_filter_ctrl.sv
// Randomised scoreboard bench for color_filter_ctrl: frames are modelled as
// lists of matched pixel coordinates and compared against the DUT's reports.
module tb_color_filter_ctrl;
  import color_filter_pkg::*;

  logic        iCLK, iRST;
  logic [10:0] iX_Cont, iY_Cont;
  logic [11:0] iRed, iGreen, iBlue;
  logic        iDVAL, iCfgValid, oCfgReady;
  logic [1:0]  iCfgAddr;
  logic [11:0] iCfgData, oRedMin, oGreenMax, oBlueMax;
  logic        oMatch, oMatchDVAL, oFrameDone, oBoxValid;
  logic [19:0] oPixCount;
  logic [10:0] oXMin, oXMax, oYMin, oYMax;

  color_filter_ctrl dut (
    .iCLK(iCLK), .iRST(iRST), .iX_Cont(iX_Cont), .iY_Cont(iY_Cont),
    .iRed(iRed), .iGreen(iGreen), .iBlue(iBlue), .iDVAL(iDVAL),
    .iCfgValid(iCfgValid), .oCfgReady(oCfgReady), .iCfgAddr(iCfgAddr),
    .iCfgData(iCfgData), .oRedMin(oRedMin), .oGreenMax(oGreenMax),
    .oBlueMax(oBlueMax), .oMatch(oMatch), .oMatchDVAL(oMatchDVAL),
    .oFrameDone(oFrameDone), .oPixCount(oPixCount), .oXMin(oXMin),
    .oXMax(oXMax), .oYMin(oYMin), .oYMax(oYMax), .oBoxValid(oBoxValid)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  typedef struct {
    int          cnt;
    logic [10:0] xmin, xmax, ymin, ymax;
    logic        bv;
  } frameExp_t;

  int assertCount = 0;
  int failCount   = 0;

  bit        matchQ[$];
  frameExp_t frameQ[$];

  logic [11:0] mAct[3];
  logic [11:0] mShd[3];
  bit          mPending, mInFrame;
  int          mHitX[$], mHitY[$];
  int          lastCnt;

  logic        cfgReqValid;
  logic [1:0]  cfgReqAddr;
  logic [11:0] cfgReqData;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Scoreboard monitor, sampling away from the active edge.
  always @(negedge iCLK) begin
    if (!iRST) begin
      if (oMatchDVAL) begin
        if (matchQ.size() == 0) check("matchDvalUnexpected", 32'(oMatchDVAL), 32'(0));
        else check("oMatch", 32'(oMatch), 32'(matchQ.pop_front()));
      end
      if (oFrameDone) begin
        if (frameQ.size() == 0) check("frameDoneUnexpected", 32'(oFrameDone), 32'(0));
        else begin
          frameExp_t e;
          e = frameQ.pop_front();
          check("oPixCount", 32'(oPixCount), 32'(e.cnt));
          check("oBoxValid", 32'(oBoxValid), 32'(e.bv));
          check("oXMin", 32'(oXMin), 32'(e.xmin));
          check("oXMax", 32'(oXMax), 32'(e.xmax));
          check("oYMin", 32'(oYMin), 32'(e.ymin));
          check("oYMax", 32'(oYMax), 32'(e.ymax));
        end
      end
    end
  end

  task automatic modelReset();
    mAct[0] = RED_MIN_DEF; mAct[1] = GREEN_MAX_DEF; mAct[2] = BLUE_MAX_DEF;
    mShd[0] = RED_MIN_DEF; mShd[1] = GREEN_MAX_DEF; mShd[2] = BLUE_MAX_DEF;
    mPending = 0; mInFrame = 0; lastCnt = 0;
    mHitX.delete(); mHitY.delete();
    matchQ.delete(); frameQ.delete();
    cfgReqValid = 1'b0; cfgReqAddr = 2'd0; cfgReqData = 12'd0;
  endtask

  task automatic checkOutput();
    check("rstCfgReady", 32'(oCfgReady), 32'(1));
    check("rstRedMin", 32'(oRedMin), 32'(12'h700));
    check("rstGreenMax", 32'(oGreenMax), 32'(12'h4FF));
    check("rstBlueMax", 32'(oBlueMax), 32'(12'h4FF));
    check("rstMatch", 32'(oMatch), 32'(0));
    check("rstMatchDval", 32'(oMatchDVAL), 32'(0));
    check("rstFrameDone", 32'(oFrameDone), 32'(0));
    check("rstPixCount", 32'(oPixCount), 32'(0));
    check("rstBox", {oXMin[7:0], oXMax[7:0], oYMin[7:0], oYMax[7:0]}, 32'(0));
    check("rstBoxHi", 32'({oXMin[10:8], oXMax[10:8], oYMin[10:8], oYMax[10:8]}), 32'(0));
    check("rstBoxValid", 32'(oBoxValid), 32'(0));
  endtask

  task automatic doReset(input int cycles);
    iRST = 1'b1; iDVAL = 1'b0; iCfgValid = 1'b0;
    repeat (cycles) @(posedge iCLK);
    #1;
    iRST = 1'b0;
    modelReset();
    checkOutput();
  endtask

  // One clock of stimulus; the reference model advances by the same cycle.
  task automatic applyStimulus(input logic dval, input logic [10:0] x, input logic [10:0] y,
                               input logic [11:0] r, input logic [11:0] g, input logic [11:0] b);
    logic [11:0] thr[3];
    bit fs, fe, hit, load, accepted;
    frameExp_t fr;
    check("oCfgReady", 32'(oCfgReady), 32'(!mPending));
    check("oRedMin", 32'(oRedMin), 32'(mAct[0]));
    check("oGreenMax", 32'(oGreenMax), 32'(mAct[1]));
    check("oBlueMax", 32'(oBlueMax), 32'(mAct[2]));
    iDVAL = dval; iX_Cont = x; iY_Cont = y; iRed = r; iGreen = g; iBlue = b;
    iCfgValid = cfgReqValid; iCfgAddr = cfgReqAddr; iCfgData = cfgReqData;
    fs = dval && x == 0 && y == 0;
    fe = dval && x == 639 && y == 479;
    load = mPending && (fs || !mInFrame);
    for (int i = 0; i < 3; i++) thr[i] = (fs && mPending) ? mShd[i] : mAct[i];
    hit = (r > thr[0]) && (g < thr[1]) && (b < thr[2]);
    if (dval) matchQ.push_back(hit);
    if (fs) begin
      mInFrame = 1; mHitX.delete(); mHitY.delete();
    end
    if (mInFrame && dval && hit) begin
      mHitX.push_back(int'(x)); mHitY.push_back(int'(y));
    end
    if (mInFrame && fe && !fs) begin
      fr.cnt = mHitX.size();
      fr.bv = (fr.cnt > 0);
      fr.xmin = 0; fr.xmax = 0; fr.ymin = 0; fr.ymax = 0;
      if (fr.cnt > 0) begin
        fr.xmin = 11'h7FF; fr.ymin = 11'h7FF;
        for (int i = 0; i < fr.cnt; i++) begin
          if (mHitX[i] < int'(fr.xmin)) fr.xmin = 11'(mHitX[i]);
          if (mHitX[i] > int'(fr.xmax)) fr.xmax = 11'(mHitX[i]);
          if (mHitY[i] < int'(fr.ymin)) fr.ymin = 11'(mHitY[i]);
          if (mHitY[i] > int'(fr.ymax)) fr.ymax = 11'(mHitY[i]);
        end
      end
      frameQ.push_back(fr);
      lastCnt = fr.cnt;
      mInFrame = 0;
    end
    accepted = cfgReqValid && !mPending;
    if (load) begin
      for (int i = 0; i < 3; i++) mAct[i] = mShd[i];
      mPending = 0;
    end
    if (accepted) begin
      if (cfgReqAddr == 2'd3) mPending = 1;
      else mShd[cfgReqAddr] = cfgReqData;
    end
    @(posedge iCLK);
    #1;
    if (accepted) cfgReqValid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 11'd0, 11'd0, 12'd0, 12'd0, 12'd0);
  endtask

  task automatic cfgPost(input logic [1:0] a, input logic [11:0] d);
    int guard = 0;
    while (cfgReqValid && guard < 2000) begin
      idle(1); guard++;
    end
    if (cfgReqValid) begin
      assertCount++; failCount++;
      $display("[TB] FAIL cfgTimeout: write still stalled after %0d cycles, expected acceptance", guard);
    end
    cfgReqValid = 1'b1; cfgReqAddr = a; cfgReqData = d;
  endtask

  function automatic logic [11:0] nearVal(input logic [11:0] t);
    case ($urandom_range(0, 3))
      0: return t - 12'd1;
      1: return t;
      2: return t + 12'd1;
      default: return 12'($urandom_range(0, 4095));
    endcase
  endfunction

  task automatic randPixel();
    applyStimulus(1'($urandom_range(0, 3) != 0), 11'($urandom_range(1, 639)),
                  11'($urandom_range(0, 478)), nearVal(mAct[0]), nearVal(mAct[1]),
                  nearVal(mAct[2]));
  endtask

  task automatic quietPixel();
    applyStimulus(1'b1, 11'($urandom_range(1, 639)), 11'($urandom_range(0, 478)),
                  12'd0, 12'($urandom), 12'($urandom));
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    iRST = 1'b1; iDVAL = 1'b0; iCfgValid = 1'b0; iCfgAddr = 2'd0; iCfgData = 12'd0;
    iX_Cont = 11'd0; iY_Cont = 11'd0; iRed = 12'd0; iGreen = 12'd0; iBlue = 12'd0;
    #1;
    doReset(3);

    // Strict red compare right after reset; the FS pixel opens a frame.
    applyStimulus(1'b1, 11'd0, 11'd0, 12'h800, 12'h100, 12'h100);
    applyStimulus(1'b1, 11'd1, 11'd0, 12'h700, 12'h100, 12'h100);
    for (int i = 0; i < 10; i++) randPixel();

    // Commit mid-frame: active holds until the next FS; further writes stall.
    cfgPost(2'd0, 12'h900); randPixel();
    cfgPost(2'd3, 12'h000); randPixel();
    cfgPost(2'd1, 12'h300);
    for (int i = 0; i < 12; i++) randPixel();
    applyStimulus(1'b1, 11'd639, 11'd479, 12'hFFF, 12'h000, 12'h000);
    applyStimulus(1'b1, 11'd0, 11'd0, 12'h901, 12'h000, 12'h000);
    for (int i = 0; i < 8; i++) randPixel();
    applyStimulus(1'b1, 11'd639, 11'd479, 12'h000, 12'h000, 12'h000);
    idle(3);

    // Commit while idle lands one cycle after acceptance.
    cfgPost(2'd2, 12'h600); idle(1);
    cfgPost(2'd3, 12'h000); idle(4);

    // Two isolated matches define the box.
    applyStimulus(1'b1, 11'd0, 11'd0, 12'h000, 12'h000, 12'h000);
    for (int i = 0; i < 5; i++) quietPixel();
    applyStimulus(1'b1, 11'd10, 11'd20, 12'hFFF, 12'h000, 12'h000);
    for (int i = 0; i < 5; i++) quietPixel();
    applyStimulus(1'b1, 11'd100, 11'd200, 12'hFFF, 12'h000, 12'h000);
    for (int i = 0; i < 5; i++) quietPixel();
    applyStimulus(1'b1, 11'd639, 11'd479, 12'h000, 12'h000, 12'h000);
    idle(2);

    // Zero-match frame.
    applyStimulus(1'b1, 11'd0, 11'd0, 12'h000, 12'h000, 12'h000);
    for (int i = 0; i < 8; i++) quietPixel();
    applyStimulus(1'b1, 11'd639, 11'd479, 12'h000, 12'h000, 12'h000);
    idle(2);

    // Random frames with random config traffic.
    for (int f = 0; f < 6; f++) begin
      applyStimulus(1'b1, 11'd0, 11'd0, nearVal(mAct[0]), nearVal(mAct[1]), nearVal(mAct[2]));
      for (int i = 0; i < 40; i++) begin
        if (!cfgReqValid && $urandom_range(0, 9) == 0)
          cfgPost(2'($urandom_range(0, 3)), 12'($urandom_range(12'h300, 12'hB00)));
        randPixel();
      end
      applyStimulus(1'b1, 11'd639, 11'd479, nearVal(mAct[0]), nearVal(mAct[1]), nearVal(mAct[2]));
      idle($urandom_range(0, 3));
    end
    idle(4);

    // Truncated frame: restart on a second FS, stats stay from the last frame.
    applyStimulus(1'b1, 11'd0, 11'd0, 12'hFFF, 12'h000, 12'h000);
    for (int i = 0; i < 6; i++) randPixel();
    applyStimulus(1'b1, 11'd0, 11'd0, 12'hFFF, 12'h000, 12'h000);
    for (int i = 0; i < 6; i++) randPixel();
    check("statsHeld", 32'(oPixCount), 32'(lastCnt));
    applyStimulus(1'b1, 11'd639, 11'd479, 12'hFFF, 12'h000, 12'h000);
    idle(3);

    // Reset mid-frame: no report, everything back to reset values.
    cfgPost(2'd0, 12'hABC); idle(1);
    cfgPost(2'd3, 12'h000); idle(2);
    applyStimulus(1'b1, 11'd0, 11'd0, 12'hFFF, 12'h000, 12'h000);
    for (int i = 0; i < 6; i++) randPixel();
    doReset(1);
    idle(5);

    check("matchQueueDrained", 32'(matchQ.size()), 32'(0));
    check("frameQueueDrained", 32'(frameQ.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
